// File: rtl/reg_write_dest_ctrl_pkg.sv
// Shared write-back destination encodings and default fixed indices.
// Used by the control FSM and the write-back destination controller.
package reg_write_dest_ctrl_pkg;

  typedef enum logic [2:0] {
    SEL_RT   = 3'b000,
    SEL_SP   = 3'b001,
    SEL_RA   = 3'b010,
    SEL_RD   = 3'b011,
    SEL_RS   = 3'b100,
    SEL_NONE = 3'b101
  } dest_sel_e;

  localparam int SP_IDX_DEF = 29;
  localparam int RA_IDX_DEF = 31;

endpackage

// File: rtl/reg_write_dest_ctrl_if.sv
// Request/drain handshake bundle of the write-back destination controller.
// master: requester + regfile side; slave: the controller.
interface reg_write_dest_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        dest_sel;
  logic [31:0]       instr;
  logic [DATA_W-1:0] wdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, dest_sel, instr, wdata, out_ready,
    input  in_ready, out_valid, out_addr, out_data
  );

  modport slave (
    input  in_valid, dest_sel, instr, wdata, out_ready,
    output in_ready, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/reg_write_dest_ctrl_wb_fifo.sv
// reg_wb_fifo: DEPTH x (addr,data) sync FIFO with per-entry valid/addr.
// Ports: push/pop, head_*, full, count, ent_valid/ent_addr for scoreboard.
module reg_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic [PW:0]              count,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [DEPTH-1:0][AW-1:0] ent_addr
);
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign full       = count == (PW+1)'(DEPTH);
  assign head_valid = ent_valid[rd_ptr];
  assign head_addr  = ent_addr[rd_ptr];
  assign head_data  = ent_data[rd_ptr];
  assign do_push    = push & ~full;
  assign do_pop     = pop & head_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_addr  <= '0;
      ent_data  <= '0;
    end else begin
      if (do_push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= push_addr;
        ent_data[wr_ptr]  <= push_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/reg_write_dest_ctrl.sv
// Write-back destination controller: decode, drop $zero/discard, queue.
// Ports: clk, reset, bus (slave), busy_mask, count, drop_cnt.
module reg_write_dest_ctrl
  import reg_write_dest_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int SP_IDX   = SP_IDX_DEF,
  parameter int RA_IDX   = RA_IDX_DEF,
  parameter int DEPTH    = 2,
  parameter int DROP_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  reg_write_dest_ctrl_if.slave     bus,
  output logic [NUM_REGS-1:0]      busy_mask,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_cnt
);
  logic [ADDR_W-1:0]            dec_addr;
  logic                         dec_none;
  logic                         accept;
  logic                         drop;
  logic                         push;
  logic                         pop;
  logic                         full;
  logic                         head_valid;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic                         unused_instr;

  assign unused_instr = ^{bus.instr[31:26], bus.instr[10:0]};

  always_comb begin
    dec_addr = '0;
    dec_none = 1'b0;
    unique case (1'b1)
      bus.dest_sel == SEL_RT: dec_addr = ADDR_W'(bus.instr[20:16]);
      bus.dest_sel == SEL_SP: dec_addr = ADDR_W'(SP_IDX);
      bus.dest_sel == SEL_RA: dec_addr = ADDR_W'(RA_IDX);
      bus.dest_sel == SEL_RD: dec_addr = ADDR_W'(bus.instr[15:11]);
      bus.dest_sel == SEL_RS: dec_addr = ADDR_W'(bus.instr[25:21]);
      default:                dec_none = 1'b1;
    endcase
  end

  // $zero is never written, so it is dropped like an explicit discard
  assign accept       = bus.in_valid & bus.in_ready;
  assign drop         = accept & (dec_none | (dec_addr == '0));
  assign push         = accept & ~drop;
  assign pop          = head_valid & bus.out_ready;
  assign bus.in_ready = ~full;

  reg_wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (dec_addr),
    .push_data  (bus.wdata),
    .pop        (pop),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .count      (count),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );

  assign bus.out_valid = head_valid;
  assign bus.out_addr  = head_valid ? head_addr : '0;
  assign bus.out_data  = head_valid ? head_data : '0;

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) busy_mask[ent_addr[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end
endmodule
